// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the rejection-sampler state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package kyber_pkg;

    localparam int KYBER_N       = 256;
    localparam int KYBER_Q       = 3329;
    localparam int At_Char_Bytes = 672;
    localparam int Byte_bits     = 8;
    localparam int COEFF_W       = 12;
    localparam int AT_BITS       = At_Char_Bytes * Byte_bits;
    localparam int NUM_CAND      = (At_Char_Bytes / 3) * 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_REFILL = 2'd2,
        ST_DONE   = 2'd3
    } rej_state_t;

endpackage

// File: rtl/kyber_rej_candidate.sv
// Splits one 3-byte triplet into two 12-bit candidates and flags those below q.
// Latency: combinational.
// Backpressure: none; the parent decides when a candidate is consumed.
module kyber_rej_candidate
    import kyber_pkg::*;
(
    input  logic [23:0]        triplet,
    output logic [COEFF_W-1:0] d1,
    output logic [COEFF_W-1:0] d2,
    output logic               d1_ok,
    output logic               d2_ok
);

    // Byte 0 sits in the top 8 bits of the triplet, byte 2 in the bottom 8.
    assign d1    = {triplet[11:8], triplet[23:16]};
    assign d2    = {triplet[7:0], triplet[15:12]};
    assign d1_ok = (d1 < COEFF_W'(KYBER_Q));
    assign d2_ok = (d2 < COEFF_W'(KYBER_Q));

endmodule

// File: rtl/kyber_rej_uniform_sampler.sv
// Kyber parse: turns SHAKE128 squeeze buffers into 256 coefficients below q.
// Latency: start -> first candidate next cycle -> earliest coefficient one cycle later.
// Backpressure: a held coefficient stalls candidate evaluation until oCoeff is taken.
module kyber_rej_uniform_sampler
    import kyber_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [AT_BITS-1:0] iAt_Char,
    input  logic               iAt_valid,
    output logic               oMore_req,
    output logic               oCoeff_valid,
    input  logic               iCoeff_ready,
    output logic [COEFF_W-1:0] oCoeff,
    output logic [7:0]         oCoeff_addr,
    output logic               oBusy,
    output logic               oDone
);

    localparam logic [8:0]  LAST_CAND = 9'(NUM_CAND - 1);
    localparam logic [8:0]  FULL_CNT  = 9'(KYBER_N);
    localparam logic [12:0] BUF_MSB   = 13'(AT_BITS - 1);

    rej_state_t         state_q;
    rej_state_t         state_d;
    logic [AT_BITS-1:0] buf_q;
    logic [8:0]         cand_idx;
    logic [8:0]         count;
    logic [12:0]        trip_msb;
    logic [23:0]        triplet;
    logic [COEFF_W-1:0] d1;
    logic [COEFF_W-1:0] d2;
    logic [COEFF_W-1:0] cand;
    logic               d1_ok;
    logic               d2_ok;
    logic               cand_ok;
    logic               slot_free;
    logic               hs;
    logic               eval;
    logic               load_new;
    logic               load_refill;

    assign trip_msb = BUF_MSB - (13'(cand_idx[8:1]) * 13'd24);
    assign triplet  = buf_q[trip_msb -: 24];

    kyber_rej_candidate u_cand (
        .triplet (triplet),
        .d1      (d1),
        .d2      (d2),
        .d1_ok   (d1_ok),
        .d2_ok   (d2_ok)
    );

    // Even candidate index picks d1, odd picks d2 of the same triplet.
    assign cand      = cand_idx[0] ? d2 : d1;
    assign cand_ok   = cand_idx[0] ? d2_ok : d1_ok;
    assign slot_free = !oCoeff_valid || iCoeff_ready;
    assign hs        = oCoeff_valid && iCoeff_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        eval        = 1'b0;
        load_new    = 1'b0;
        load_refill = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_new = 1'b1;
                    state_d  = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                eval = slot_free && (count != FULL_CNT);
                // Once 256 are accepted only the final handshake matters.
                if (hs && (count == FULL_CNT)) begin
                    state_d = ST_DONE;
                end else if (eval && (cand_idx == LAST_CAND) &&
                             !(cand_ok && (count == FULL_CNT - 9'd1))) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (iAt_valid) begin
                    load_refill = 1'b1;
                    state_d     = ST_SAMPLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q        <= '0;
            cand_idx     <= '0;
            count        <= '0;
            oCoeff       <= '0;
            oCoeff_addr  <= '0;
            oCoeff_valid <= 1'b0;
        end else begin
            if (load_new || load_refill) begin
                buf_q    <= iAt_Char;
                cand_idx <= '0;
            end else if (eval && (cand_idx != LAST_CAND)) begin
                cand_idx <= cand_idx + 9'd1;
            end

            if (load_new) begin
                count <= '0;
            end

            if (eval && cand_ok) begin
                oCoeff       <= cand;
                oCoeff_addr  <= count[7:0];
                oCoeff_valid <= 1'b1;
                count        <= count + 9'd1;
            end else if (hs) begin
                oCoeff_valid <= 1'b0;
            end
        end
    end

    assign oMore_req = (state_q == ST_REFILL);
    assign oBusy     = (state_q != ST_IDLE);
    assign oDone     = (state_q == ST_DONE);

endmodule

// File: tb/tb_kyber_rej_uniform_sampler.sv
// Bench for the Kyber rejection sampler: byte-level parse model, random ready,
// refill feeding, busy-start and mid-run reset scenarios.
module tb_kyber_rej_uniform_sampler;

    localparam int AT = 5376;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AT-1:0] iAt_Char = '0;
    logic          iAt_valid = 1'b0;
    logic          oMore_req;
    logic          oCoeff_valid;
    logic          iCoeff_ready = 1'b0;
    logic [11:0]   oCoeff;
    logic [7:0]    oCoeff_addr;
    logic          oBusy;
    logic          oDone;

    int n_checks = 0;
    int n_pass   = 0;

    logic [AT-1:0] buf_list[4];
    int            n_bufs;
    logic [11:0]   exp_q[$];
    int            exp_refills;

    always #5 clk = ~clk;

    kyber_rej_uniform_sampler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .iAt_Char     (iAt_Char),
        .iAt_valid    (iAt_valid),
        .oMore_req    (oMore_req),
        .oCoeff_valid (oCoeff_valid),
        .iCoeff_ready (iCoeff_ready),
        .oCoeff       (oCoeff),
        .oCoeff_addr  (oCoeff_addr),
        .oBusy        (oBusy),
        .oDone        (oDone)
    );

    // kind 0: 01 23 45 repeated; 1: 00 1D D0 repeated; 2: all FF;
    // 3: 96 triplets of FF then the 01 23 45 pattern; 4: random bytes.
    function automatic logic [AT-1:0] pattern_buf(input int kind);
        logic [AT-1:0] b;
        logic [7:0]    v;
        b = '0;
        for (int k = 0; k < 672; k++) begin
            case (kind)
                0: v = (k % 3 == 0) ? 8'h01 : (k % 3 == 1) ? 8'h23 : 8'h45;
                1: v = (k % 3 == 0) ? 8'h00 : (k % 3 == 1) ? 8'h1D : 8'hD0;
                2: v = 8'hFF;
                3: v = (k < 288) ? 8'hFF :
                       (k % 3 == 0) ? 8'h01 : (k % 3 == 1) ? 8'h23 : 8'h45;
                default: v = 8'($urandom_range(0, 255));
            endcase
            b[AT-1-8*k -: 8] = v;
        end
        return b;
    endfunction

    function automatic int get_byte(input logic [AT-1:0] bv, input int k);
        return int'(bv[AT-1-8*k -: 8]);
    endfunction

    // Software parse over the buffer list, stopping at 256 accepted values.
    function automatic void build_expected();
        int b0, b1, b2, d1, d2;
        exp_q.delete();
        exp_refills = 0;
        for (int b = 0; b < n_bufs && exp_q.size() < 256; b++) begin
            if (b > 0) exp_refills++;
            for (int t = 0; t < 224 && exp_q.size() < 256; t++) begin
                b0 = get_byte(buf_list[b], 3*t);
                b1 = get_byte(buf_list[b], 3*t + 1);
                b2 = get_byte(buf_list[b], 3*t + 2);
                d1 = b0 + 256 * (b1 % 16);
                d2 = (b1 / 16) + 16 * b2;
                if (d1 < 3329) exp_q.push_back(12'(d1));
                if (exp_q.size() < 256 && d2 < 3329) exp_q.push_back(12'(d2));
            end
        end
    endfunction

    task automatic run_poly(input int ready_pct, input int exp_more_cyc,
                            input int exp_done_cyc, input bit poke_start,
                            input bit noise_valid, input string tag);
        int          cyc, got, refills, next_buf, wait_ref, last_hs, done_cyc;
        bit          prev_stall, prev_more, fed_prev, done_seen;
        logic [11:0] prev_c;
        logic [7:0]  prev_a;
        build_expected();
        got = 0; refills = 0; next_buf = 1; wait_ref = 0; last_hs = -1;
        done_cyc = -1; prev_stall = 0; prev_more = 0; fed_prev = 0; done_seen = 0;
        prev_c = '0; prev_a = '0;
        @(negedge clk);
        iAt_Char = buf_list[0]; start = 1'b1; iAt_valid = 1'b0; iCoeff_ready = 1'b0;
        for (cyc = 1; cyc < 4000 && !done_seen; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            iAt_valid = 1'b0;
            if (prev_stall) begin
                n_checks++;
                if (!(oCoeff_valid === 1'b1 && oCoeff === prev_c && oCoeff_addr === prev_a))
                    $display("FAIL %s stall_hold cyc=%0d got v=%b c=%0d a=%0d want v=1 c=%0d a=%0d",
                             tag, cyc, oCoeff_valid, oCoeff, oCoeff_addr, prev_c, prev_a);
                else n_pass++;
            end
            if (fed_prev) begin
                n_checks++;
                if (oMore_req !== 1'b0)
                    $display("FAIL %s more_fall cyc=%0d got %b want 0", tag, cyc, oMore_req);
                else n_pass++;
            end
            fed_prev = 0;
            if (oMore_req === 1'b1) begin
                if (!prev_more) begin
                    refills++;
                    wait_ref = 2;
                    if (refills == 1 && exp_more_cyc >= 0) begin
                        n_checks++;
                        if (cyc != exp_more_cyc)
                            $display("FAIL %s more_rise_cycle got %0d want %0d", tag, cyc, exp_more_cyc);
                        else n_pass++;
                    end
                end
                if (wait_ref > 0) wait_ref--;
                else if (next_buf < n_bufs) begin
                    iAt_Char  = buf_list[next_buf];
                    iAt_valid = 1'b1;
                    next_buf++;
                    fed_prev  = 1;
                end
            end else if (noise_valid && $urandom_range(0, 3) == 0) begin
                iAt_Char  = '0;
                iAt_valid = 1'b1;
            end
            if (poke_start && cyc == 40 && !iAt_valid) begin
                iAt_Char = '0;
                start    = 1'b1;
            end
            prev_more = (oMore_req === 1'b1);
            iCoeff_ready = ($urandom_range(0, 99) < ready_pct);
            if (oCoeff_valid === 1'b1 && iCoeff_ready) begin
                n_checks++;
                if (got >= exp_q.size())
                    $display("FAIL %s extra_coeff idx=%0d got c=%0d want none", tag, got, oCoeff);
                else if (oCoeff !== exp_q[got] || oCoeff_addr !== got[7:0])
                    $display("FAIL %s coeff idx=%0d got c=%0d a=%0d want c=%0d a=%0d",
                             tag, got, oCoeff, oCoeff_addr, exp_q[got], got[7:0]);
                else n_pass++;
                got++;
                last_hs = cyc;
            end
            prev_stall = (oCoeff_valid === 1'b1) && !iCoeff_ready;
            prev_c = oCoeff;
            prev_a = oCoeff_addr;
            if (oDone === 1'b1) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
        iCoeff_ready = 1'b0;
        start = 1'b0;
        iAt_valid = 1'b0;
        n_checks++;
        if (!done_seen) $display("FAIL %s done_timeout got no oDone want oDone", tag);
        else n_pass++;
        n_checks++;
        if (got != 256) $display("FAIL %s coeff_count got %0d want 256", tag, got);
        else n_pass++;
        n_checks++;
        if (done_cyc != last_hs + 1)
            $display("FAIL %s done_after_last got cyc %0d want %0d", tag, done_cyc, last_hs + 1);
        else n_pass++;
        if (exp_done_cyc >= 0) begin
            n_checks++;
            if (done_cyc != exp_done_cyc)
                $display("FAIL %s done_cycle got %0d want %0d", tag, done_cyc, exp_done_cyc);
            else n_pass++;
        end
        n_checks++;
        if (refills != exp_refills)
            $display("FAIL %s refills got %0d want %0d", tag, refills, exp_refills);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (oDone !== 1'b0 || oBusy !== 1'b0 || oCoeff_valid !== 1'b0)
            $display("FAIL %s post_done got done=%b busy=%b v=%b want 0 0 0",
                     tag, oDone, oBusy, oCoeff_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({oCoeff_valid, oMore_req, oBusy, oDone} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {oCoeff_valid, oMore_req, oBusy, oDone});
        else n_pass++;
        n_checks++;
        if (oCoeff !== 12'd0 || oCoeff_addr !== 8'd0)
            $display("FAIL reset_data got c=%0d a=%0d want 0 0", oCoeff, oCoeff_addr);
        else n_pass++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (oBusy !== 1'b0) $display("FAIL idle_after_reset got busy=%b want 0", oBusy);
        else n_pass++;
    endtask

    task automatic test_all_accept();
        buf_list[0] = pattern_buf(0); n_bufs = 1;
        run_poly(100, -1, 258, 0, 0, "all_accept");
    endtask

    task automatic test_q_boundary();
        buf_list[0] = pattern_buf(1); buf_list[1] = pattern_buf(1); n_bufs = 2;
        run_poly(100, 449, -1, 0, 0, "q_boundary");
    endtask

    task automatic test_refill_ff();
        buf_list[0] = pattern_buf(2); buf_list[1] = pattern_buf(0); n_bufs = 2;
        run_poly(100, 449, -1, 0, 0, "refill_ff");
    endtask

    task automatic test_last_candidate();
        buf_list[0] = pattern_buf(3); buf_list[1] = pattern_buf(0); n_bufs = 2;
        run_poly(100, -1, 450, 0, 0, "last_cand");
    endtask

    task automatic test_random_ready();
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 4; b++) buf_list[b] = pattern_buf(4);
            n_bufs = 4;
            run_poly(50, -1, -1, 0, 1, "random_ready");
        end
    endtask

    task automatic test_start_while_busy();
        buf_list[0] = pattern_buf(0); n_bufs = 1;
        run_poly(60, -1, -1, 1, 0, "busy_start");
        buf_list[0] = pattern_buf(4); buf_list[1] = pattern_buf(4); n_bufs = 2;
        run_poly(100, -1, -1, 0, 0, "second_start");
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 0;
        @(negedge clk);
        iAt_Char = pattern_buf(0); start = 1'b1; iCoeff_ready = 1'b1;
        for (int cyc = 1; cyc < 400 && !hit; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (oCoeff_valid === 1'b1 && oCoeff_addr === 8'd100) hit = 1;
        end
        n_checks++;
        if (!hit) $display("FAIL reset_mid_reach got no addr 100 want addr 100");
        else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({oCoeff_valid, oMore_req, oBusy, oDone, oCoeff, oCoeff_addr} !== 24'h0)
            $display("FAIL reset_mid_async got v=%b m=%b b=%b d=%b c=%0d a=%0d want all 0",
                     oCoeff_valid, oMore_req, oBusy, oDone, oCoeff, oCoeff_addr);
        else n_pass++;
        iCoeff_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        buf_list[0] = pattern_buf(0); n_bufs = 1;
        run_poly(70, -1, -1, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_all_accept();
        test_q_boundary();
        test_refill_ff();
        test_last_candidate();
        test_random_ready();
        test_start_while_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kyber_rej_uniform_sampler.md
# kyber_rej_uniform_sampler

Consumes the 672-byte SHAKE128 squeeze buffer (`oAt_Char`) produced by the hash/permutation stage and turns it into one uniformly random polynomial of the public matrix A by Kyber rejection sampling (parse). Accepted 12-bit coefficients (< q) stream out over a valid/ready port to the matrix/NTT memory writer. If the buffer runs out before 256 coefficients are accepted, the block requests another squeeze block from upstream.

## Interface
- `KYBER_N`, 256, coefficients per polynomial
- `KYBER_Q`, 3329, modulus; acceptance bound
- `At_Char_Bytes`, 672, bytes per input buffer (224 triplets, 448 candidates)
- `Byte_bits`, 8, bits per byte
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; capture `iAt_Char`, begin a polynomial
- `iAt_Char`  in  5376  squeeze buffer; byte k = `iAt_Char[5375-8k -: 8]` (byte 0 in MSB)
- `iAt_valid`  in  1  new buffer present on `iAt_Char` (used only in REFILL)
- `oMore_req`  out  1  buffer exhausted; level held until `iAt_valid`
- `oCoeff_valid`  out  1  coefficient on `oCoeff` valid
- `iCoeff_ready`  in  1  sink accepts coefficient
- `oCoeff`  out  12  accepted coefficient, 0..3328
- `oCoeff_addr`  out  8  coefficient index 0..255
- `oBusy`  out  1  high in any state except IDLE
- `oDone`  out  1  one-cycle pulse after 256th handshake

## Operation
- Triplet t uses bytes b0=3t, b1=3t+1, b2=3t+2: d1 = b0 | (b1[3:0]<<8); d2 = b1[7:4] | (b2<<4). Candidate order: d1 then d2, t ascending.
- Accept iff candidate < `KYBER_Q` (unsigned 12-bit compare). Rejected candidates consume one cycle, produce nothing.
- States: IDLE → (start) SAMPLE → DONE → IDLE; SAMPLE → REFILL when candidate index reaches 448 with count < 256; REFILL → SAMPLE on `iAt_valid` (load buffer, candidate index ← 0, count kept).
- SAMPLE: candidate evaluated only when output slot free (`!oCoeff_valid || iCoeff_ready`); accepted → register `oCoeff`, `oCoeff_addr`=count, set valid, count++.
- Count reaching 256 on handshake → DONE; remaining candidates discarded. DONE lasts one cycle, drives `oDone`=1.
- `start` ignored while `oBusy`. `iAt_valid` ignored outside REFILL.
- Output held stable while `oCoeff_valid && !iCoeff_ready`.

## Timing
- Reset values: all outputs 0; state IDLE; count 0; candidate index 0; buffer 0.
- Reset asserted mid-operation: immediate return to IDLE, partial polynomial abandoned, no `oDone`.
- Cycle 0 `start`; cycle 1 first candidate evaluated; earliest `oCoeff_valid` cycle 2.
- Throughput: one candidate per cycle, ≤ 1 coefficient per cycle; all-accept with ready high → 256th valid cycle 257, `oDone` cycle 258.
- `oMore_req` rises the cycle after the 448th candidate evaluates; falls the cycle after `iAt_valid` sampled; sampling resumes that same cycle.
- Final candidate (index 447) accepted as 256th coefficient → DONE, no refill.
- Stall on 256th coefficient: DONE entered only after its handshake.

## Structure
- Shared package/header `kyber_pkg`: `KYBER_N`, `KYBER_Q`, `At_Char_Bytes`, coefficient width (12), state encodings.
- Sub-module `kyber_rej_candidate`: combinational extract of d1/d2 from a 24-bit triplet plus both < q flags; instantiated once, byte mux in parent.
- Parent: FSM, 5376-bit buffer register, 9-bit candidate index, 9-bit count, output register.

## Test plan
- Buffer of repeated bytes 0x01,0x23,0x45, ready high → coefficients 769,1106 alternating, addr 0..255, `oDone` at cycle 258, `oMore_req` never set.
- Triplets encoding d1=3328, d2=3329 (0x00,0x1D,0xD0) → only 3328 emitted per triplet; 3329 rejected; 224 coefficients then `oMore_req`=1.
- All-0xFF buffer → no `oCoeff_valid`; `oMore_req` rises cycle 449; supplying 0x01,0x23,0x45 buffer with `iAt_valid` → completes 256 coefficients addr 0..255.
- Random `iCoeff_ready` toggling (~50%) → `oCoeff`/`oCoeff_addr` stable while stalled, no loss/duplication vs. software parse model.
- `start` pulsed while busy → ignored; second `start` after `oDone` → new polynomial from addr 0.
- `reset_n` low at coefficient 100 → all outputs 0 asynchronously; fresh `start` afterwards yields full correct polynomial.
